// File: rtl/hilo_acc.sv
// HI/LO register pair with a two-cycle multiply-accumulate unit (MADDU/MADD/MSUBU/MSUB).
// Optional macro HILO_BYPASS_EN forwards direct-write data to hi_o/lo_o in the write cycle.
module hilo_acc #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_hi,
    input  logic              we_lo,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    input  logic              acc_valid,
    input  logic [1:0]        acc_op,
    input  logic [DATA_W-1:0] acc_a,
    input  logic [DATA_W-1:0] acc_b,
    input  logic              flush,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              busy,
    output logic              acc_done
);

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t              state, state_d;
    logic [DATA_W-1:0]   hi_q, lo_q, hi_d, lo_d;
    logic [2*DATA_W-1:0] prod_q, prod_d;
    logic [2*DATA_W-1:0] a_ext, b_ext, acc_res;
    logic [1:0]          op_q, op_d;
    logic                done_q, done_d;

    // acc_op[0] selects signed operands; a 2*DATA_W product of extended operands
    // is exact modulo 2^(2*DATA_W) for both signednesses.
    assign a_ext   = acc_op[0] ? {{DATA_W{acc_a[DATA_W-1]}}, acc_a} : {{DATA_W{1'b0}}, acc_a};
    assign b_ext   = acc_op[0] ? {{DATA_W{acc_b[DATA_W-1]}}, acc_b} : {{DATA_W{1'b0}}, acc_b};
    assign acc_res = op_q[1] ? ({hi_q, lo_q} - prod_q) : ({hi_q, lo_q} + prod_q);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state;
        hi_d    = hi_q;
        lo_d    = lo_q;
        prod_d  = prod_q;
        op_d    = op_q;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (we_hi) hi_d = hi_i;
                if (we_lo) lo_d = lo_i;
                if (acc_valid && !flush) begin
                    prod_d  = a_ext * b_ext;
                    op_d    = acc_op;
                    state_d = MUL;
                end
            end
            MUL: begin
                // acc_valid is deliberately ignored here: nothing is queued behind a busy unit.
                state_d = IDLE;
                if (we_hi || we_lo) begin
                    if (we_hi) hi_d = hi_i;
                    if (we_lo) lo_d = lo_i;
                end else if (!flush) begin
                    {hi_d, lo_d} = acc_res;
                    done_d       = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state  <= IDLE;
            hi_q   <= '0;
            lo_q   <= '0;
            prod_q <= '0;
            op_q   <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            prod_q <= prod_d;
            op_q   <= op_d;
            done_q <= done_d;
        end
    end

    assign busy     = (state == MUL);
    assign acc_done = done_q;

`ifdef HILO_BYPASS_EN
    assign hi_o = (we_hi && !rst) ? hi_i : hi_q;
    assign lo_o = (we_lo && !rst) ? lo_i : lo_q;
`else
    assign hi_o = hi_q;
    assign lo_o = lo_q;
`endif

endmodule

// File: tb/tb_hilo_acc.sv
// Directed self-checking bench for hilo_acc (DATA_W=32): reset, direct writes,
// all four accumulate modes, flush, write priority, ignored requests and reset in MUL.
module tb_hilo_acc;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, we_hi, we_lo, acc_valid, flush;
    logic [W-1:0] hi_i, lo_i, acc_a, acc_b;
    logic [1:0]   acc_op;
    logic [W-1:0] hi_o, lo_o;
    logic         busy, acc_done;

    int n_cmp = 0;
    int n_bad = 0;

    hilo_acc #(.DATA_W(W)) dut (
        .clk(clk), .rst(rst), .we_hi(we_hi), .we_lo(we_lo), .hi_i(hi_i), .lo_i(lo_i),
        .acc_valid(acc_valid), .acc_op(acc_op), .acc_a(acc_a), .acc_b(acc_b), .flush(flush),
        .hi_o(hi_o), .lo_o(lo_o), .busy(busy), .acc_done(acc_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; we_hi = 1'b0; we_lo = 1'b0; hi_i = '0; lo_i = '0;
        acc_valid = 1'b0; acc_op = 2'b00; acc_a = '0; acc_b = '0; flush = 1'b0;
    endtask

    task automatic randomize_inputs();
        we_hi = 1'($urandom_range(1)); we_lo = 1'($urandom_range(1));
        hi_i = $urandom(); lo_i = $urandom();
        acc_valid = 1'($urandom_range(1)); acc_op = 2'($urandom_range(3));
        acc_a = $urandom(); acc_b = $urandom(); flush = 1'($urandom_range(1));
    endtask

    task automatic start_acc(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        acc_valid = 1'b1; acc_op = op; acc_a = a; acc_b = b;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        randomize_inputs();
        step();
        randomize_inputs();
        step();
        n_cmp++; if (hi_o !== 32'h0) begin n_bad++; $display("FAIL reset_hi: got %h want %h", hi_o, 32'h0); end
        n_cmp++; if (lo_o !== 32'h0) begin n_bad++; $display("FAIL reset_lo: got %h want %h", lo_o, 32'h0); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (acc_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", acc_done); end
        idle_inputs();
    endtask

    task automatic test_direct_write();
        logic [W-1:0] same_cycle_exp;
`ifdef HILO_BYPASS_EN
        same_cycle_exp = 32'h12345678;
`else
        same_cycle_exp = 32'h0;
`endif
        we_hi = 1'b1; hi_i = 32'h12345678; lo_i = 32'hDEADBEEF;
        #1;
        n_cmp++; if (hi_o !== same_cycle_exp) begin n_bad++; $display("FAIL write_same_cycle_hi: got %h want %h", hi_o, same_cycle_exp); end
        n_cmp++; if (lo_o !== 32'h0) begin n_bad++; $display("FAIL write_same_cycle_lo: got %h want %h", lo_o, 32'h0); end
        step();
        idle_inputs();
        n_cmp++; if (hi_o !== 32'h12345678) begin n_bad++; $display("FAIL write_hi: got %h want %h", hi_o, 32'h12345678); end
        n_cmp++; if (lo_o !== 32'h0) begin n_bad++; $display("FAIL write_lo_unsel: got %h want %h", lo_o, 32'h0); end
        // LO only: HI must keep its value.
        we_lo = 1'b1; lo_i = 32'hFFFFFFFF; hi_i = 32'h0BADF00D;
        step();
        idle_inputs();
        n_cmp++; if (hi_o !== 32'h12345678) begin n_bad++; $display("FAIL write_hi_unsel: got %h want %h", hi_o, 32'h12345678); end
        n_cmp++; if (lo_o !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL write_lo: got %h want %h", lo_o, 32'hFFFFFFFF); end
        we_hi = 1'b1; hi_i = 32'h0;
        step();
        idle_inputs();
        n_cmp++; if (hi_o !== 32'h0) begin n_bad++; $display("FAIL write_hi_zero: got %h want %h", hi_o, 32'h0); end
    endtask

    task automatic test_maddu();
        start_acc(2'b00, 32'd2, 32'd3);
        step();
        idle_inputs();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL maddu_busy: got %b want 1", busy); end
        n_cmp++; if (acc_done !== 1'b0) begin n_bad++; $display("FAIL maddu_done_early: got %b want 0", acc_done); end
        n_cmp++; if ({hi_o, lo_o} !== 64'h00000000_FFFFFFFF) begin n_bad++; $display("FAIL maddu_hold: got %h want %h", {hi_o, lo_o}, 64'h00000000_FFFFFFFF); end
        step();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL maddu_busy_clr: got %b want 0", busy); end
        n_cmp++; if (acc_done !== 1'b1) begin n_bad++; $display("FAIL maddu_done: got %b want 1", acc_done); end
        n_cmp++; if (hi_o !== 32'h1) begin n_bad++; $display("FAIL maddu_hi: got %h want %h", hi_o, 32'h1); end
        n_cmp++; if (lo_o !== 32'h5) begin n_bad++; $display("FAIL maddu_lo: got %h want %h", lo_o, 32'h5); end
        step();
        n_cmp++; if (acc_done !== 1'b0) begin n_bad++; $display("FAIL maddu_done_pulse: got %b want 0", acc_done); end
    endtask

    task automatic test_signed_modes();
        logic [1:0]   ops  [4] = '{2'b01, 2'b11, 2'b00, 2'b10};
        logic [W-1:0] as   [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [W-1:0] bs   [4] = '{32'h1, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF};
        // MADD -1*1; MSUB -1*1; MADDU (2^32-1)^2; MSUBU (2^32-1)^2.
        logic [2*W-1:0] exp [4] = '{64'hFFFFFFFF_FFFFFFFF, 64'h0, 64'hFFFFFFFE_00000001, 64'h0};
        we_hi = 1'b1; we_lo = 1'b1; hi_i = '0; lo_i = '0;
        step();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            start_acc(ops[i], as[i], bs[i]);
            step();
            idle_inputs();
            step();
            n_cmp++; if ({hi_o, lo_o} !== exp[i]) begin n_bad++; $display("FAIL mode_%0d_result: got %h want %h", i, {hi_o, lo_o}, exp[i]); end
            n_cmp++; if (acc_done !== 1'b1) begin n_bad++; $display("FAIL mode_%0d_done: got %b want 1", i, acc_done); end
        end
    endtask

    task automatic test_flush();
        start_acc(2'b00, 32'd5, 32'd5);
        step();
        idle_inputs();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL flush_busy: got %b want 1", busy); end
        flush = 1'b1;
        step();
        idle_inputs();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy_clr: got %b want 0", busy); end
        n_cmp++; if (acc_done !== 1'b0) begin n_bad++; $display("FAIL flush_done: got %b want 0", acc_done); end
        n_cmp++; if ({hi_o, lo_o} !== 64'h0) begin n_bad++; $display("FAIL flush_hilo: got %h want %h", {hi_o, lo_o}, 64'h0); end
        step();
        n_cmp++; if (acc_done !== 1'b0) begin n_bad++; $display("FAIL flush_done_late: got %b want 0", acc_done); end
    endtask

    task automatic test_write_in_mul();
        start_acc(2'b00, 32'd5, 32'd5);
        step();
        idle_inputs();
        we_lo = 1'b1; lo_i = 32'hA5A5A5A5;
        start_acc(2'b00, 32'd7, 32'd7);
        step();
        idle_inputs();
        n_cmp++; if (lo_o !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL wmul_lo: got %h want %h", lo_o, 32'hA5A5A5A5); end
        n_cmp++; if (hi_o !== 32'h0) begin n_bad++; $display("FAIL wmul_hi: got %h want %h", hi_o, 32'h0); end
        n_cmp++; if (acc_done !== 1'b0) begin n_bad++; $display("FAIL wmul_done: got %b want 0", acc_done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wmul_busy: got %b want 0", busy); end
        step();
        n_cmp++; if (acc_done !== 1'b0) begin n_bad++; $display("FAIL wmul_done_late: got %b want 0", acc_done); end
        n_cmp++; if ({hi_o, lo_o} !== 64'h00000000_A5A5A5A5) begin n_bad++; $display("FAIL wmul_hilo_late: got %h want %h", {hi_o, lo_o}, 64'h00000000_A5A5A5A5); end
    endtask

    task automatic test_flush_idle();
        // acc_valid with flush must not start; a same-cycle write still lands.
        start_acc(2'b00, 32'd9, 32'd9);
        flush = 1'b1; we_hi = 1'b1; hi_i = 32'h7;
        step();
        idle_inputs();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL fidle_busy: got %b want 0", busy); end
        n_cmp++; if ({hi_o, lo_o} !== 64'h00000007_A5A5A5A5) begin n_bad++; $display("FAIL fidle_hilo: got %h want %h", {hi_o, lo_o}, 64'h00000007_A5A5A5A5); end
    endtask

    task automatic test_write_and_start();
        // The write at the start edge is part of the accumulate base.
        we_lo = 1'b1; lo_i = 32'h10;
        start_acc(2'b00, 32'd3, 32'd4);
        step();
        idle_inputs();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL wstart_busy: got %b want 1", busy); end
        n_cmp++; if (lo_o !== 32'h10) begin n_bad++; $display("FAIL wstart_lo_mid: got %h want %h", lo_o, 32'h10); end
        step();
        n_cmp++; if ({hi_o, lo_o} !== 64'h00000007_0000001C) begin n_bad++; $display("FAIL wstart_hilo: got %h want %h", {hi_o, lo_o}, 64'h00000007_0000001C); end
        n_cmp++; if (acc_done !== 1'b1) begin n_bad++; $display("FAIL wstart_done: got %b want 1", acc_done); end
    endtask

    task automatic test_back_to_back();
        // A request held high through MUL is ignored there, not queued.
        we_hi = 1'b1; we_lo = 1'b1; hi_i = '0; lo_i = '0;
        step();
        idle_inputs();
        start_acc(2'b00, 32'd1, 32'd1);
        step();
        start_acc(2'b00, 32'd100, 32'd100);
        step();
        idle_inputs();
        n_cmp++; if (lo_o !== 32'h1) begin n_bad++; $display("FAIL b2b_lo: got %h want %h", lo_o, 32'h1); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy: got %b want 0", busy); end
        step();
        n_cmp++; if ({hi_o, lo_o} !== 64'h1) begin n_bad++; $display("FAIL b2b_hilo_late: got %h want %h", {hi_o, lo_o}, 64'h1); end
        n_cmp++; if (acc_done !== 1'b0) begin n_bad++; $display("FAIL b2b_done_late: got %b want 0", acc_done); end
    endtask

    task automatic test_reset_in_mul();
        start_acc(2'b00, 32'd5, 32'd5);
        step();
        idle_inputs();
        rst = 1'b1;
        step();
        idle_inputs();
        n_cmp++; if ({hi_o, lo_o} !== 64'h0) begin n_bad++; $display("FAIL rmul_hilo: got %h want %h", {hi_o, lo_o}, 64'h0); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmul_busy: got %b want 0", busy); end
        n_cmp++; if (acc_done !== 1'b0) begin n_bad++; $display("FAIL rmul_done: got %b want 0", acc_done); end
        step();
        n_cmp++; if ({hi_o, lo_o} !== 64'h0) begin n_bad++; $display("FAIL rmul_hilo_late: got %h want %h", {hi_o, lo_o}, 64'h0); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_direct_write();
        test_maddu();
        test_signed_modes();
        test_flush();
        test_write_in_mul();
        test_flush_idle();
        test_write_and_start();
        test_back_to_back();
        test_reset_in_mul();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hilo_acc.md
HILO_ACC -- requirements
Module: hilo_acc

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the width of HI, LO and each accumulate operand.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high (`RstEnable).
REQ-004 we_hi  input  1  direct write enable for HI.
REQ-005 we_lo  input  1  direct write enable for LO, independent of we_hi.
REQ-006 hi_i  input  DATA_W  direct write data for HI.
REQ-007 lo_i  input  DATA_W  direct write data for LO.
REQ-008 acc_valid  input  1  start accumulate request.
REQ-009 acc_op  input  2  accumulate mode: 00 MADDU, 01 MADD, 10 MSUBU, 11 MSUB.
REQ-010 acc_a  input  DATA_W  multiplicand.
REQ-011 acc_b  input  DATA_W  multiplier.
REQ-012 flush  input  1  abort any accumulate in progress.
REQ-013 hi_o  output  DATA_W  HI read value.
REQ-014 lo_o  output  DATA_W  LO read value.
REQ-015 busy  output  1  high while an accumulate is in progress (stall to issue logic).
REQ-016 acc_done  output  1  one-cycle pulse when an accumulate result has been committed.

Function
REQ-017 FSM SHALL have two states, IDLE and MUL; busy SHALL equal (state==MUL), decoded from the state register.
REQ-018 In IDLE, on an edge with acc_valid=1 and flush=0: product register <= acc_a*acc_b (2*DATA_W bits), op latched, state -> MUL.
REQ-019 Product SHALL be signed for MADD/MSUB and unsigned for MADDU/MSUBU.
REQ-020 In MUL, on the next edge: {hi,lo} <= {hi,lo} + product (MADD/MADDU) or {hi,lo} - product (MSUB/MSUBU), modulo 2^(2*DATA_W); state -> IDLE; acc_done registered high for exactly the following cycle.
REQ-021 Latency: acc_valid sampled at edge N; {hi_o,lo_o} SHALL show the result after edge N+1; acc_done SHALL be high in the cycle after edge N+1.
REQ-022 Accumulation SHALL use HI/LO values as held at edge N+1, including any direct write applied at edge N.
REQ-023 acc_valid while busy=1 SHALL be ignored; it is neither queued nor started.
REQ-024 Direct write outside MUL: at the edge, HI <= hi_i if we_hi; LO <= lo_i if we_lo; unselected half unchanged.
REQ-025 Direct write (either enable) in MUL SHALL take priority: the write is applied, the accumulate is cancelled, state -> IDLE, and acc_done stays 0.
REQ-026 flush in MUL SHALL cancel the accumulate: HI/LO unchanged, state -> IDLE, acc_done stays 0.
REQ-027 flush SHALL NOT suppress direct writes in the same cycle.
REQ-028 acc_valid with flush in the same IDLE cycle SHALL NOT start an accumulate.

Reset
REQ-029 With rst=1 at an edge: HI=LO=0, state=IDLE, product register=0, acc_done=0, so busy=0.
REQ-030 rst SHALL override every other input, including during MUL; no partial result is written.

Configuration
REQ-031 Macro HILO_BYPASS_EN defined: hi_o = (we_hi && !rst) ? hi_i : HI register, and lo_o likewise with we_lo/lo_i, combinationally in the write cycle.
REQ-032 HILO_BYPASS_EN undefined: hi_o/lo_o SHALL be the HI/LO registers directly; a write becomes visible only after its edge.

Verification (DATA_W=32)
REQ-033 rst=1 for 2 cycles with all inputs random -> hi_o=lo_o=0, busy=0, acc_done=0.
REQ-034 HI=LO=0; we_hi=1, hi_i=0x12345678, we_lo=0 -> after edge hi_o=0x12345678, lo_o=0; same-cycle hi_o=0x12345678 with HILO_BYPASS_EN, 0 without.
REQ-035 HI=0, LO=0xFFFFFFFF; MADDU a=2, b=3 -> busy=1 for one cycle, then HI=0x00000001, LO=0x00000005, acc_done pulses once.
REQ-036 HI=LO=0; MADD a=0xFFFFFFFF, b=1 -> HI=LO=0xFFFFFFFF; then MSUB a=0xFFFFFFFF, b=1 -> HI=LO=0.
REQ-037 HI=LO=0; MADDU a=5, b=5; flush=1 in MUL -> HI=LO=0, busy=0 next cycle, acc_done never asserted.
REQ-038 HI=LO=0; MADDU a=5, b=5; in MUL drive we_lo=1, lo_i=0xA5A5A5A5 and acc_valid=1 -> LO=0xA5A5A5A5, HI=0, acc_done=0, no second accumulate starts.
